// File: rtl/mmio_mailbox_pkg.sv
// Shared definitions for the MMIO mailbox: register offsets,
// CTRL/STATUS bit positions and the default window base.
package mmio_mailbox_pkg;

    localparam logic [31:0] DEF_BASE  = 32'h0000_0100;
    localparam int          DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_RXDATA = 2'd1,
        REG_STATUS = 2'd2,
        REG_CTRL   = 2'd3
    } reg_off_e;

    localparam int CTRL_RX_POP   = 0;
    localparam int CTRL_TX_FLUSH = 1;
    localparam int CTRL_RX_FLUSH = 2;
    localparam int CTRL_CLR_OVF  = 3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_TX_CNT   = 8;
    localparam int ST_RX_CNT   = 16;

    typedef struct packed {
        logic clr_ovf;
        logic rx_flush;
        logic tx_flush;
        logic rx_pop;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [31:0] w);
        ctrl_t c;
        c.rx_pop   = w[CTRL_RX_POP];
        c.tx_flush = w[CTRL_TX_FLUSH];
        c.rx_flush = w[CTRL_RX_FLUSH];
        c.clr_ovf  = w[CTRL_CLR_OVF];
        return c;
    endfunction

endpackage

// File: rtl/mmio_mailbox_fifo.sv
// Small synchronous FIFO with flush; full/empty use pre-edge
// state so a push to a full FIFO is dropped even with a pop.
module mmio_mailbox_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 wdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic [W-1:0]                 head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = cnt;
    assign head    = mem[rptr];

    // Pointer and occupancy tracking; flush overrides push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/mmio_mailbox.sv
// CPU-facing mailbox: decodes a 16-byte window and bridges
// word accesses to a TX stream and from an RX stream.
module mmio_mailbox
    import mmio_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE  = DEF_BASE,
    parameter int          DEPTH = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rd,
    output logic        hit,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    reg_off_e      off;
    logic          wr;
    logic          tx_wr;
    logic          ctrl_wr;
    ctrl_t         ctrl;

    logic          tx_full;
    logic          tx_empty;
    logic [CW-1:0] tx_cnt;
    logic [31:0]   tx_head;
    logic          tx_pop;
    logic          tx_flush;

    logic          rx_full;
    logic          rx_empty;
    logic [CW-1:0] rx_cnt;
    logic [31:0]   rx_head;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_flush;

    logic          tx_ovf;
    logic          ovf_set;
    logic          ovf_clr;
    logic [31:0]   status;
    logic          unused_addr;

    assign hit         = (address[31:4] == BASE[31:4]);
    assign off         = reg_off_e'(address[3:2]);
    assign wr          = we & hit;
    assign tx_wr       = wr & (off == REG_TXDATA);
    assign ctrl_wr     = wr & (off == REG_CTRL);
    assign ctrl        = decode_ctrl(wd);
    assign unused_addr = ^address[1:0];

    assign tx_flush = ctrl_wr & ctrl.tx_flush;
    assign rx_flush = ctrl_wr & ctrl.rx_flush;
    assign rx_pop   = ctrl_wr & ctrl.rx_pop;
    assign ovf_clr  = ctrl_wr & ctrl.clr_ovf;

    // A push lost to a full FIFO is an overflow, unless a
    // flush on the same edge discards everything anyway.
    assign ovf_set  = tx_wr & tx_full & ~tx_flush;

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_head;
    assign tx_pop   = tx_valid & tx_ready;

    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & rx_ready;

    mmio_mailbox_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_wr),
        .pop   (tx_pop),
        .flush (tx_flush),
        .wdata (wd),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_cnt),
        .head  (tx_head)
    );

    mmio_mailbox_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .wdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_cnt),
        .head  (rx_head)
    );

    // Sticky overflow flag; a new overflow beats a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf <= 1'b0;
        end else if (ovf_set) begin
            tx_ovf <= 1'b1;
        end else if (ovf_clr) begin
            tx_ovf <= 1'b0;
        end
    end

    // Pack the STATUS word from FIFO flags and counts.
    always_comb begin
        status                     = '0;
        status[ST_TX_FULL]         = tx_full;
        status[ST_TX_EMPTY]        = tx_empty;
        status[ST_RX_FULL]         = rx_full;
        status[ST_RX_EMPTY]        = rx_empty;
        status[ST_TX_OVF]          = tx_ovf;
        status[ST_TX_CNT +: CW]    = tx_cnt;
        status[ST_RX_CNT +: CW]    = rx_cnt;
    end

    // Read mux; zero outside the window and for write-only regs.
    always_comb begin
        rd = '0;
        if (hit) begin
            unique case (off)
                REG_TXDATA: rd = '0;
                REG_RXDATA: rd = rx_empty ? '0 : rx_head;
                REG_STATUS: rd = status;
                REG_CTRL:   rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_mailbox.sv
// Scoreboard bench for mmio_mailbox: queue-based reference
// model, directed scenarios, then randomized bus traffic.
module tb_mmio_mailbox;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
    logic        hit;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_ready;

    typedef struct {
        logic [31:0] rd;
        logic        hit;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [31:0] exp_tx[$];
    logic [31:0] tx_m[$];
    logic [31:0] rx_m[$];
    logic [31:0] rx_src[$];
    bit          ovf_m;
    bit          mon_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    mmio_mailbox #(
        .BASE  (BASE),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .wd       (wd),
        .we       (we),
        .rd       (rd),
        .hit      (hit),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int t;
        int r;
        t = tx_m.size();
        r = rx_m.size();
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd1: return (r > 0) ? rx_m[0] : 32'h0;
            2'd2: return r * 65536 + t * 256
                       + (ovf_m ? 16 : 0)
                       + (r == 0 ? 8 : 0)
                       + (r == DEPTH ? 4 : 0)
                       + (t == 0 ? 2 : 0)
                       + (t == DEPTH ? 1 : 0);
            default: return 32'h0;
        endcase
    endfunction

    // Effect of one rising edge on the reference model.
    task automatic model_step();
        int          ts;
        int          rs;
        bit          wr;
        bit          txhs;
        bit          rxhs;
        logic [31:0] c;
        logic [31:0] dmy;
        if (!reset) begin
            tx_m.delete();
            exp_tx.delete();
            rx_m.delete();
            ovf_m = 1'b0;
            return;
        end
        ts   = tx_m.size();
        rs   = rx_m.size();
        wr   = we && (address[31:4] == BASE[31:4]);
        c    = (wr && address[3:2] == 2'd3) ? wd : 32'h0;
        txhs = tx_ready && ts > 0;
        rxhs = rx_valid && rs < DEPTH;
        if (c[3]) ovf_m = 1'b0;
        if (c[1]) begin
            tx_m.delete();
            exp_tx.delete();
        end else begin
            if (txhs) dmy = tx_m.pop_front();
            if (wr && address[3:2] == 2'd0) begin
                if (ts < DEPTH) begin
                    tx_m.push_back(wd);
                    exp_tx.push_back(wd);
                end else begin
                    ovf_m = 1'b1;
                end
            end
        end
        if (c[2]) begin
            rx_m.delete();
        end else begin
            if (c[0] && rs > 0) dmy = rx_m.pop_front();
            if (rxhs) rx_m.push_back(rx_data);
        end
        if (rxhs) dmy = rx_src.pop_front();
    endtask

    task automatic drive_rx();
        rx_valid = (rx_src.size() > 0);
        rx_data  = rx_valid ? rx_src[0] : $urandom;
    endtask

    // One bus cycle: queue expected read, then clock the model.
    task automatic cycle();
        rd_exp_t e;
        drive_rx();
        e.rd  = model_rd(address);
        e.hit = (address[31:4] == BASE[31:4]);
        rd_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        we = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr_addr(input logic [31:0] a, input logic [31:0] d);
        address = a;
        wd      = d;
        we      = 1'b1;
        cycle();
        we      = 1'b0;
    endtask

    task automatic wr_reg(input int off, input logic [31:0] d);
        wr_addr(BASE + 32'(off * 4), d);
    endtask

    task automatic peek(input string nm, input int off,
                        input logic [31:0] mask,
                        input logic [31:0] exp);
        address = BASE + 32'(off * 4);
        we      = 1'b0;
        #1;
        chk(nm, rd & mask, exp);
    endtask

    // Monitor: pops expectations whenever the DUT presents data.
    always @(negedge clk) begin
        rd_exp_t e;
        if (mon_en) begin
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                chk("rd", rd, e.rd);
                chk("hit", {31'd0, hit}, {31'd0, e.hit});
            end
            chk("tx_valid", {31'd0, tx_valid},
                {31'd0, exp_tx.size() != 0});
            chk("rx_ready", {31'd0, rx_ready},
                {31'd0, rx_m.size() < DEPTH});
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_extra: got %h, required none",
                             tx_data);
                end else begin
                    chk("tx_data", tx_data, exp_tx.pop_front());
                end
            end
        end
    end

    initial begin
        int          r;
        logic [31:0] c;
        reset    = 1'b0;
        address  = 32'h0;
        wd       = 32'h0;
        we       = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 32'h0;
        mon_en   = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(1);

        // Reset in the middle of traffic
        wr_reg(0, 32'h1234_0001);
        wr_reg(0, 32'h1234_0002);
        rx_src.push_back(32'h7700_0001);
        idle(2);
        reset = 1'b0;
        tx_m.delete();
        exp_tx.delete();
        rx_m.delete();
        rx_src.delete();
        ovf_m = 1'b0;
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_tx_data", tx_data, 32'h0);
        peek("rst_status", 2, 32'hFFFF_FFFF, 32'h0000_000A);
        idle(2);
        reset = 1'b1;
        idle(1);

        // TX fill with backpressure, then drain in order
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr_reg(0, 32'hA5A5_0000 + 32'(i));
        peek("tx_cnt4", 2, 32'h0000_0F01, 32'h0000_0401);
        tx_ready = 1'b1;
        idle(5);
        chk("tx_drained", {31'd0, tx_valid}, 32'd0);

        // Overflow and sticky flag clear
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr_reg(0, 32'hC0DE_0000 + 32'(i));
        wr_reg(0, 32'hDEAD_BEEF);
        peek("ovf_set", 2, 32'h0000_0010, 32'h0000_0010);
        wr_reg(3, 32'h8);
        peek("ovf_clr", 2, 32'h0000_0010, 32'h0);
        tx_ready = 1'b1;
        idle(5);
        tx_ready = 1'b0;

        // RX peek and pop
        rx_src.push_back(32'h11);
        rx_src.push_back(32'h22);
        idle(3);
        peek("rx_peek1", 1, 32'hFFFF_FFFF, 32'h11);
        idle(1);
        peek("rx_peek2", 1, 32'hFFFF_FFFF, 32'h11);
        wr_reg(3, 32'h1);
        peek("rx_pop1", 1, 32'hFFFF_FFFF, 32'h22);
        wr_reg(3, 32'h1);
        peek("rx_pop2", 1, 32'hFFFF_FFFF, 32'h0);
        peek("rx_empty", 2, 32'h0000_0008, 32'h0000_0008);

        // RX backpressure: fifth word waits for a pop
        for (int i = 1; i <= 5; i++) rx_src.push_back(32'h5000_0000 + 32'(i));
        idle(6);
        chk("rx_full_ready", {31'd0, rx_ready}, 32'd0);
        peek("rx_cnt4", 2, 32'h0007_0004, 32'h0004_0004);
        wr_reg(3, 32'h1);
        idle(1);
        peek("rx_after_pop", 1, 32'hFFFF_FFFF, 32'h5000_0002);
        peek("rx_cnt4b", 2, 32'h0007_0000, 32'h0004_0000);
        wr_reg(3, 32'h4);
        peek("rx_flushed", 2, 32'h0007_0008, 32'h0000_0008);

        // Concurrency and window boundary
        tx_ready = 1'b0;
        wr_reg(0, 32'h6000_0001);
        wr_reg(0, 32'h6000_0002);
        tx_ready = 1'b1;
        wr_reg(0, 32'h6000_0003);
        tx_ready = 1'b0;
        peek("tx_cnt_same", 2, 32'h0000_0F00, 32'h0000_0200);
        wr_reg(0, 32'h6000_0004);
        wr_reg(0, 32'h6000_0005);
        wr_reg(3, 32'h2);
        peek("tx_flushed", 2, 32'h0000_0F13, 32'h0000_0002);
        rx_src.push_back(32'h6600_0001);
        wr_reg(3, 32'h4);
        peek("rx_flush_push", 2, 32'h0007_0008, 32'h0000_0008);
        wr_addr(BASE + 32'h10, 32'h0000_000F);
        address = BASE + 32'h10;
        #1;
        chk("off_hit", {31'd0, hit}, 32'd0);
        chk("off_rd", rd, 32'h0);
        peek("off_nochg", 2, 32'hFFFF_FFFF, 32'h0000_000A);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && rx_src.size() < 6)
                rx_src.push_back($urandom);
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                wr_reg(0, $urandom);
            end else if (r == 3) begin
                c = 32'h0;
                c[0] = ($urandom_range(0, 1) == 0);
                c[1] = ($urandom_range(0, 7) == 0);
                c[2] = ($urandom_range(0, 7) == 0);
                c[3] = ($urandom_range(0, 3) == 0);
                wr_reg(3, c);
            end else if (r == 4) begin
                wr_reg($urandom_range(1, 2), $urandom);
            end else if (r == 5) begin
                wr_addr($urandom & 32'hFFFF_FFFC, $urandom);
            end else begin
                address = BASE + 32'($urandom_range(0, 3) * 4);
                we      = 1'b0;
                cycle();
            end
        end

        // Final drain
        tx_ready = 1'b1;
        rx_src.delete();
        idle(8);
        chk("final_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("final_exp_left", 32'(exp_tx.size()), 32'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
